// File: rtl/dead_detect.sv
`default_nettype none
// ============================================================================
//  Module   : dead_detect
//  Purpose  : Game-over detector for the bird-height datapath. Compares the
//             current bird height against ceiling/floor bounds every clock
//             and raises a sticky is_dead flag once the bird leaves the
//             playfield, plus a one-cycle dead_pulse on the 0->1 transition.
//  Ports    : clk        in   system clock, rising edge
//             rst_n      in   asynchronous active-low reset
//             restart    in   synchronous clear of the dead state (new game)
//             height     in   current bird height, unsigned pixels [WIDTH]
//             is_dead    out  sticky game-over flag, registered
//             dead_pulse out  one-cycle strobe when is_dead goes 0->1
//  Revision : 1.0  initial release
// ============================================================================
module dead_detect #(
    parameter int WIDTH      = 9,
    parameter int MIN_HEIGHT = 20,
    parameter int MAX_HEIGHT = 460
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [WIDTH-1:0] height,
    output logic             is_dead,
    output logic             dead_pulse
);

    // Bounds reduced to the bus width so the compare is a plain unsigned
    // WIDTH-bit compare with no sign extension.
    localparam logic [WIDTH-1:0] c_min_height = MIN_HEIGHT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_max_height = MAX_HEIGHT[WIDTH-1:0];

    // Reject bound settings that cannot be represented or are inverted.
    if ((MIN_HEIGHT < 0) || (MIN_HEIGHT > MAX_HEIGHT) ||
        (MAX_HEIGHT >= (1 << WIDTH))) begin : g_param_check
        $error("dead_detect: require 0 <= MIN_HEIGHT <= MAX_HEIGHT < 2**WIDTH");
    end

    typedef enum logic [0:0] {
        ST_ALIVE = 1'b0,
        ST_DEAD  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_dead_pulse;
    logic   w_pulse_next;
    logic   w_out_of_bounds;

    // Both bounds are legal (alive); only strictly outside is fatal.
    assign w_out_of_bounds = (height < c_min_height) || (height > c_max_height);

    always_comb begin
        w_state_next = r_state;
        w_pulse_next = 1'b0;
        if (restart) begin
            // restart wins over a simultaneous out-of-bounds height.
            w_state_next = ST_ALIVE;
        end else if ((r_state == ST_ALIVE) && w_out_of_bounds) begin
            w_state_next = ST_DEAD;
            w_pulse_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ALIVE;
            r_dead_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dead_pulse <= w_pulse_next;
        end
    end

    assign is_dead    = (r_state == ST_DEAD);
    assign dead_pulse = r_dead_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dead_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dead_detect
//  Purpose  : Self-checking bench for dead_detect: directed reset, sweep,
//             bound, restart and async-reset steps followed by randomized
//             height/restart traffic, all checked against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dead_detect;

    localparam int WIDTH  = 9;
    localparam int LO     = 20;
    localparam int HI     = 460;

    logic             clk;
    logic             rst_n;
    logic             restart;
    logic [WIDTH-1:0] height;
    logic             is_dead;
    logic             dead_pulse;

    int n_pass;
    int n_total;

    // Reference model state: game-over flag and the strobe.
    bit m_dead;
    bit m_pulse;

    dead_detect #(
        .WIDTH      (WIDTH),
        .MIN_HEIGHT (LO),
        .MAX_HEIGHT (HI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .height     (height),
        .is_dead    (is_dead),
        .dead_pulse (dead_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_both(input string tag);
        check({tag, ".is_dead"}, is_dead, m_dead);
        check({tag, ".dead_pulse"}, dead_pulse, m_pulse);
    endtask

    // Apply inputs, take one rising edge, advance the model from the rules
    // of the game, then compare just after the edge.
    task automatic step(input int h, input bit r, input string tag);
        height  = h[WIDTH-1:0];
        restart = r;
        @(posedge clk);
        if (!rst_n) begin
            m_dead  = 1'b0;
            m_pulse = 1'b0;
        end else if (r) begin
            m_dead  = 1'b0;
            m_pulse = 1'b0;
        end else if (m_dead) begin
            m_pulse = 1'b0;
        end else if (h < LO || h > HI) begin
            m_dead  = 1'b1;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
        end
        #1;
        check_both(tag);
    endtask

    initial begin
        int h;
        bit r;
        n_pass  = 0;
        n_total = 0;
        m_dead  = 1'b0;
        m_pulse = 1'b0;

        // Reset held with a fatal height: outputs stay low throughout.
        rst_n   = 1'b0;
        restart = 1'b0;
        height  = 9'd500;
        #1;
        check_both("reset_t0");
        for (int i = 0; i < 3; i++) step(500, 0, "reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(250, 0, "reset_release");

        // Upward sweep through the ceiling-of-range and the 511->0 wrap.
        for (int v = 250; v <= 530; v++) step(v % 512, 0, "sweep");

        // Restart with a legal height, then sit on the lower bound.
        step(250, 1, "restart_legal");
        step(250, 0, "restart_after");
        for (int i = 0; i < 4; i++) step(LO, 0, "lower_bound");
        step(HI, 0, "upper_bound");
        step(LO - 1, 0, "below_min");
        step(LO - 1, 0, "below_min_hold");
        step(250, 0, "dead_sticky");

        // restart held with fatal height keeps alive; release dies next edge.
        for (int i = 0; i < 3; i++) step(5, 1, "restart_held");
        step(5, 0, "restart_drop");
        step(5, 0, "restart_drop_after");

        // Async reset between edges while dead.
        #3;
        rst_n = 1'b0;
        m_dead  = 1'b0;
        m_pulse = 1'b0;
        #1;
        check_both("async_reset");
        step(5, 0, "async_reset_held");
        rst_n = 1'b1;
        step(250, 0, "async_release");
        step(250, 0, "async_release2");

        // Randomized traffic, biased toward the bounds.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       h = $urandom_range(LO - 2, LO + 2);
                1:       h = $urandom_range(HI - 2, HI + 2);
                default: h = $urandom_range(0, 511);
            endcase
            r = ($urandom_range(0, 9) == 0);
            step(h, r, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
